// File: rtl/laser_power_monitor.sv
// laser_power_monitor
//   Screens an interleaved ADC sample stream against per-channel peak limits
//   while laser_pulse is high, and against CW/leakage limits while it is low.
//   A channel faults after TRIP_CNT consecutive over-limit samples. The fault
//   stays latched until clear_fail. The block also reports the per-pulse
//   maximum of each channel.
// Ports
//   clk, rstn     : clock, asynchronous active-low reset
//   laser_pulse   : emission window, synchronous to clk
//   sample_valid  : qualifies sample_ch / sample_value for one cycle
//   sample_ch     : channel index of the sample
//   sample_value  : unsigned ADC sample
//   peak_limit    : per-channel peak limit, channel i at [i*DW +: DW]
//   cw_limit      : per-channel CW limit, same packing
//   clear_fail    : per-channel fault clear, level-sampled
//   peak_fail     : latched peak-limit fault per channel
//   cw_fail       : latched CW-limit fault per channel
//   any_fail      : OR of all fault bits (combinational from fault registers)
//   peak_hold     : per-channel maximum sample of the last completed pulse
module laser_power_monitor #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned DW       = 16,
  parameter int unsigned TRIP_CNT = 3
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   laser_pulse,
  input  logic                                   sample_valid,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] sample_ch,
  input  logic [DW-1:0]                          sample_value,
  input  logic [NCH*DW-1:0]                      peak_limit,
  input  logic [NCH*DW-1:0]                      cw_limit,
  input  logic [NCH-1:0]                         clear_fail,
  output logic [NCH-1:0]                         peak_fail,
  output logic [NCH-1:0]                         cw_fail,
  output logic                                   any_fail,
  output logic [NCH*DW-1:0]                      peak_hold
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CNTW = 8;
  localparam logic [CNTW-1:0] TRIP = CNTW'(TRIP_CNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    TRIPPED = 2'd2
  } state_t;

  logic [NCH*DW-1:0] peak_limit_q;
  logic [NCH*DW-1:0] cw_limit_q;
  logic              lp_d1;
  logic              rise;
  logic              fall;
  logic              ch_valid;

  // Quasi-static limits and the laser_pulse delay for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      peak_limit_q <= '0;
      cw_limit_q   <= '0;
      lp_d1        <= 1'b0;
    end else begin
      peak_limit_q <= peak_limit;
      cw_limit_q   <= cw_limit;
      lp_d1        <= laser_pulse;
    end
  end

  assign rise     = laser_pulse & ~lp_d1;
  assign fall     = ~laser_pulse & lp_d1;
  // Out-of-range channel indices never reach any channel.
  assign ch_valid = sample_valid && ({1'b0, sample_ch} < (CHW+1)'(NCH));

  assign any_fail = |{peak_fail, cw_fail};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t          st_q, st_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_base;
    logic [DW-1:0]   max_q, max_d, max_base;
    logic [DW-1:0]   hold_q, hold_d;
    logic [DW-1:0]   lim;
    logic            pf_q, pf_d, cf_q, cf_d;
    logic            hit;
    logic            over;

    assign hit  = ch_valid && (sample_ch == CHW'(g));
    // Phase follows the current laser_pulse level, so edge cycles use the new phase.
    assign lim  = laser_pulse ? peak_limit_q[g*DW +: DW] : cw_limit_q[g*DW +: DW];
    assign over = sample_value > lim;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        max_q  <= '0;
        hold_q <= '0;
        pf_q   <= 1'b0;
        cf_q   <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        max_q  <= max_d;
        hold_q <= hold_d;
        pf_q   <= pf_d;
        cf_q   <= cf_d;
      end
    end

    // Next state: clear > trip > edge-induced counter reset > sample count.
    always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      max_d    = max_q;
      hold_d   = hold_q;
      pf_d     = pf_q;
      cf_d     = cf_q;
      cnt_base = cnt_q;
      max_base = max_q;

      case (st_q)
        TRIPPED: begin
          if (clear_fail[g]) begin
            st_d  = IDLE;
            pf_d  = 1'b0;
            cf_d  = 1'b0;
            cnt_d = '0;
            max_d = '0;
          end
        end
        default: begin
          if (st_q == IDLE && rise) begin
            st_d     = PULSE;
            cnt_base = '0;
            max_base = '0;
          end else if (st_q == PULSE && fall) begin
            st_d     = IDLE;
            cnt_base = '0;
            hold_d   = max_q;
          end
          cnt_d = cnt_base;
          max_d = max_base;
          // A sample arriving together with clear_fail is discarded.
          if (hit && !clear_fail[g]) begin
            if (laser_pulse && (sample_value > max_base)) begin
              max_d = sample_value;
            end
            if (over) begin
              cnt_d = (cnt_base >= TRIP) ? TRIP : cnt_base + CNTW'(1);
              if (cnt_d == TRIP) begin
                st_d = TRIPPED;
                if (laser_pulse) begin
                  pf_d = 1'b1;
                end else begin
                  cf_d = 1'b1;
                end
              end
            end else begin
              cnt_d = '0;
            end
          end
        end
      endcase
    end

    assign peak_fail[g]          = pf_q;
    assign cw_fail[g]            = cf_q;
    assign peak_hold[g*DW +: DW] = hold_q;
  end

endmodule

// File: tb/tb_laser_power_monitor.sv
// Testbench for laser_power_monitor: table-driven one-cycle vectors with
// expected fault/hold values, plus hand-written reset sequences.
module tb_laser_power_monitor;

  localparam int NCH = 5;
  localparam int DW  = 16;
  localparam int TC  = 3;

  logic              clk;
  logic              rstn;
  logic              laser_pulse;
  logic              sample_valid;
  logic [2:0]        sample_ch;
  logic [DW-1:0]     sample_value;
  logic [NCH*DW-1:0] peak_limit;
  logic [NCH*DW-1:0] cw_limit;
  logic [NCH-1:0]    clear_fail;
  logic [NCH-1:0]    peak_fail;
  logic [NCH-1:0]    cw_fail;
  logic              any_fail;
  logic [NCH*DW-1:0] peak_hold;

  int n_cmp;
  int n_err;

  laser_power_monitor #(.NCH(NCH), .DW(DW), .TRIP_CNT(TC)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .laser_pulse  (laser_pulse),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_value (sample_value),
    .peak_limit   (peak_limit),
    .cw_limit     (cw_limit),
    .clear_fail   (clear_fail),
    .peak_fail    (peak_fail),
    .cw_fail      (cw_fail),
    .any_fail     (any_fail),
    .peak_hold    (peak_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          lp;
    logic          vld;
    logic [2:0]    ch;
    logic [DW-1:0] val;
    logic [4:0]    clr;
    logic [4:0]    epf;
    logic [4:0]    ecf;
    logic          eany;
    int            hch;
    logic [DW-1:0] ehold;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic lp, input logic vld, input logic [2:0] ch,
                               input logic [DW-1:0] val, input logic [4:0] clr,
                               input logic [4:0] epf, input logic [4:0] ecf,
                               input logic eany, input int hch, input logic [DW-1:0] ehold);
    vec_t v;
    v.lp = lp; v.vld = vld; v.ch = ch; v.val = val; v.clr = clr;
    v.epf = epf; v.ecf = ecf; v.eany = eany; v.hch = hch; v.ehold = ehold;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic lp, input logic vld, input logic [2:0] ch,
                       input logic [DW-1:0] val, input logic [4:0] clr);
    laser_pulse  = lp;
    sample_valid = vld;
    sample_ch    = ch;
    sample_value = val;
    clear_fail   = clr;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".peak_fail"}, 96'(peak_fail), 96'(0));
    chk({name, ".cw_fail"},   96'(cw_fail),   96'(0));
    chk({name, ".any_fail"},  96'(any_fail),  96'(0));
    chk({name, ".peak_hold"}, 96'(peak_hold), 96'(0));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b1;
    drive(1'b0, 1'b0, 3'd0, '0, '0);
    // Limits, channel 0..4.
    peak_limit = {16'd100, 16'd1000, 16'd1000, 16'd1000, 16'd2000};
    cw_limit   = {16'd10,  16'd100,  16'd50,   16'd100,  16'd100};

    #2 rstn = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    step();
    step();

    // ch1 peak trip, 999 breaks the run.
    addv(1, 1, 1, 1001, 0, 0, 0, 0, -1, 0);
    addv(1, 1, 1, 1001, 0, 0, 0, 0, -1, 0);
    addv(1, 1, 1,  999, 0, 0, 0, 0, -1, 0);
    addv(1, 1, 1, 1001, 0, 0, 0, 0, -1, 0);
    addv(1, 1, 1, 1001, 0, 0, 0, 0, -1, 0);
    addv(1, 1, 1, 1001, 0, 5'b00010, 0, 1, -1, 0);
    addv(1, 1, 0, 1500, 0, 5'b00010, 0, 1, 0, 0);
    addv(0, 0, 0,    0, 5'b00010, 0, 0, 0, 0, 1500);
    // ch2 CW: equal passes, strictly greater counts.
    for (int k = 0; k < 5; k++) addv(0, 1, 2, 50, 0, 0, 0, 0, -1, 0);
    addv(0, 1, 2, 51, 0, 0, 0, 0, -1, 0);
    addv(0, 1, 2, 51, 0, 0, 0, 0, -1, 0);
    addv(0, 1, 2, 51, 0, 0, 5'b00100, 1, -1, 0);
    addv(0, 0, 0,  0, 5'b00100, 0, 0, 0, -1, 0);
    // ch0 peak hold across two pulses.
    addv(1, 1, 0,  10, 0, 0, 0, 0, 0, 1500);
    addv(1, 1, 0, 700, 0, 0, 0, 0, 0, 1500);
    addv(1, 1, 0, 300, 0, 0, 0, 0, 0, 1500);
    addv(0, 0, 0,   0, 0, 0, 0, 0, 0, 700);
    addv(0, 0, 0,   0, 0, 0, 0, 0, 0, 700);
    addv(1, 1, 0,  20, 0, 0, 0, 0, 0, 700);
    addv(1, 1, 0,  15, 0, 0, 0, 0, 0, 700);
    addv(0, 0, 0,   0, 0, 0, 0, 0, 0, 20);
    // ch3: rising edge clears the counter.
    addv(0, 1, 3,  150, 0, 0, 0, 0, -1, 0);
    addv(0, 1, 3,  150, 0, 0, 0, 0, -1, 0);
    addv(1, 0, 0,    0, 0, 0, 0, 0, -1, 0);
    addv(1, 1, 3, 1001, 0, 0, 0, 0, -1, 0);
    addv(1, 1, 3, 1001, 0, 0, 0, 0, -1, 0);
    addv(1, 1, 3, 1001, 0, 5'b01000, 0, 1, -1, 0);
    // ch3: clear discards the coincident sample; invalid channel ignored.
    addv(1, 1, 3, 1001, 5'b01000, 0, 0, 0, -1, 0);
    addv(1, 1, 3, 1001, 0, 0, 0, 0, -1, 0);
    addv(1, 1, 3, 1001, 0, 0, 0, 0, -1, 0);
    addv(1, 1, 3, 1001, 0, 5'b01000, 0, 1, -1, 0);
    for (int k = 0; k < 3; k++) addv(1, 1, 5, 16'hffff, 0, 5'b01000, 0, 1, -1, 0);
    addv(1, 1, 7, 16'hffff, 0, 5'b01000, 0, 1, -1, 0);
    addv(0, 0, 0, 0, 5'b01000, 0, 0, 0, 0, 0);
    // ch4: falling-edge cycle already screens against the CW limit.
    addv(1, 1, 4, 150, 0, 0, 0, 0, -1, 0);
    addv(1, 1, 4, 150, 0, 0, 0, 0, -1, 0);
    addv(0, 1, 4,  50, 0, 0, 0, 0, 4, 150);
    addv(0, 1, 4,  50, 0, 0, 0, 0, -1, 0);
    addv(0, 1, 4,  50, 0, 0, 5'b10000, 1, -1, 0);
    addv(0, 0, 0,   0, 5'b10000, 0, 0, 0, 4, 150);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].lp, vecs[k].vld, vecs[k].ch, vecs[k].val, vecs[k].clr);
      step();
      chk($sformatf("v%0d.peak_fail", k), 96'(peak_fail), 96'(vecs[k].epf));
      chk($sformatf("v%0d.cw_fail", k),   96'(cw_fail),   96'(vecs[k].ecf));
      chk($sformatf("v%0d.any_fail", k),  96'(any_fail),  96'(vecs[k].eany));
      if (vecs[k].hch >= 0)
        chk($sformatf("v%0d.peak_hold%0d", k, vecs[k].hch),
            96'(peak_hold[vecs[k].hch*DW +: DW]), 96'(vecs[k].ehold));
    end

    // Reset mid-pulse with a latched fault and ch0 counter at 2.
    drive(1, 1, 1, 1001, 0);
    step();
    step();
    step();
    chk("pre_rst.peak_fail", 96'(peak_fail), 96'(5'b00010));
    drive(1, 1, 0, 2001, 0);
    step();
    step();
    drive(1, 0, 0, 0, 0);
    #3 rstn = 1'b0;
    #1 chk_all_zero("mid_rst");
    @(posedge clk);
    #3 rstn = 1'b1;
    step();
    drive(1, 1, 0, 2001, 0);
    step();
    chk("post_rst1.peak_fail", 96'(peak_fail), 96'(0));
    chk("post_rst1.any_fail",  96'(any_fail),  96'(0));
    step();
    chk("post_rst2.peak_fail", 96'(peak_fail), 96'(0));
    step();
    chk("post_rst3.peak_fail", 96'(peak_fail), 96'(5'b00001));
    chk("post_rst3.any_fail",  96'(any_fail),  96'(1));
    drive(0, 0, 0, 0, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/laser_power_monitor.md
# laser_power_monitor

Multi-channel successor to the single-channel laser peak/CW power checker. It screens an interleaved ADC sample stream against per-channel peak-power limits (while `laser_pulse` is high) and CW/leakage limits (while low). A fault is declared only after `TRIP_CNT` consecutive over-limit samples, and each fault is latched per channel until cleared. The block also reports the per-pulse maximum of each channel. It sits between the ADC sequencer and the safety interlock logic.

## Interface
- `NCH`, 4: number of monitored channels (1..16)
- `DW`, 16: sample and limit width, unsigned
- `TRIP_CNT`, 3: consecutive over-limit samples required to trip (1..255)
- `clk`  in  1: clock
- `rstn`  in  1: reset, asynchronous, active-low
- `laser_pulse`  in  1: laser emission window, synchronous to `clk`
- `sample_valid`  in  1: one-cycle qualifier for `sample_ch`/`sample_value`
- `sample_ch`  in  $clog2(NCH) (min 1): channel index of the sample
- `sample_value`  in  DW: ADC sample
- `peak_limit`  in  NCH*DW: per-channel peak limit, channel i at bits [i*DW +: DW]
- `cw_limit`  in  NCH*DW: per-channel CW limit, same packing
- `clear_fail`  in  NCH: per-channel fault clear, level-sampled
- `peak_fail`  out  NCH: latched peak-limit fault
- `cw_fail`  out  NCH: latched CW-limit fault
- `any_fail`  out  1: OR of all `peak_fail` and `cw_fail` bits
- `peak_hold`  out  NCH*DW: per-channel maximum sample of the last completed pulse

## Operation
- Limits are registered once (`*_limit_q`). Comparisons use the registered copy. Limits are quasi-static.
- `laser_pulse` is registered to `lp_d1`. Rising edge = `laser_pulse & ~lp_d1`. Falling edge = `~laser_pulse & lp_d1`.
- Per-channel state machine: IDLE (CW screening), PULSE (peak screening), TRIPPED.
  - IDLE -> PULSE on rising edge. This clears the over-counter and the running max.
  - PULSE -> IDLE on falling edge. This clears the over-counter and copies the running max to `peak_hold[i]`.
  - IDLE or PULSE -> TRIPPED when the over-counter reaches `TRIP_CNT`.
  - TRIPPED -> IDLE on `clear_fail[i]`. This clears the fault bits, counter and running max. `peak_hold` is preserved.
- Sample handling: a sample applies only when `sample_valid=1` and `sample_ch < NCH`. Samples outside this range are silently ignored.
  - Phase is taken from the `laser_pulse` level in the sample's cycle: 1 = peak, 0 = CW. The edge cycle therefore already uses the new phase.
  - Over-limit means strictly `sample_value > limit_q`. Equal to the limit is a pass.
  - Over-limit increments the channel counter. A pass resets it to 0.
  - Counter width is 8 bits and saturates at `TRIP_CNT`.
  - The running max updates only in peak phase, including in the edge cycle.
- Trip: `peak_fail[i]` is set if the tripping sample was peak phase, otherwise `cw_fail[i]` is set. Only one fault bit is set per trip.
- TRIPPED ignores samples and `laser_pulse` edges. Other channels keep operating.
- Priority in one cycle for the same channel: `clear_fail` > trip > edge-induced counter reset > sample count. A sample arriving in a clear cycle is discarded.
- A sample in an edge cycle is counted after the edge-induced counter clear (counter becomes 0 or 1).

## Timing
- Reset values: `peak_fail=0`, `cw_fail=0`, `any_fail=0`, `peak_hold=0`. All channels start in IDLE with counters 0, running max 0, `lp_d1=0`, `limit_q=0`.
- Latency: the tripping sample in cycle N gives a registered fault bit at the start of cycle N+1. `any_fail` is combinational from the fault registers, so it also rises in N+1.
- Limit change in cycle N is effective for samples in cycle N+1 or later.
- `peak_hold[i]` updates in cycle N+1 after a falling edge in cycle N.
- Reset asserted mid-pulse or mid-count returns everything to reset values immediately. There is no resume.
- Throughput: one sample per cycle, any channel order.

## Test plan
- TRIP_CNT=3, ch1 `peak_limit=1000`, pulse high, ch1 samples 1001, 1001, 999, 1001, 1001, 1001 -> `peak_fail[1]` rises exactly 1 cycle after the 6th sample. Ch0 and `cw_fail` stay 0.
- Pulse low, ch2 `cw_limit=50`, samples 50 x5 then 51 x3 -> no trip on the equal values. `cw_fail[2]` and `any_fail` rise after the third 51.
- Ch0 pulse samples 10, 700, 300, then falling edge -> `peak_hold[0]=700` one cycle after the edge. A following pulse with max 20 leaves 700 until its own falling edge, then 20.
- Two over-limit samples, then a rising edge, then one over-limit sample -> no trip, because the edge cleared the counter.
- Trip ch3, then assert `clear_fail[3]` in the same cycle as an over-limit ch3 sample -> fault clears and the sample is discarded. A new trip needs 3 fresh samples. `sample_ch=NCH` never affects any channel.
- Assert `rstn=0` mid-pulse with ch0 counter at 2 -> all outputs 0 immediately. After release, 1 over-limit sample does not trip.
